// File: rtl/rule110_frame_rx.sv
// Rule 110 generation-stream receiver: deserializes 16-bit words into a 256-bit frame
// and optionally checks each frame against the Rule 110 successor of the previous one.

module rule110_cell (
  input  logic l,
  input  logic c,
  input  logic r,
  output logic n
);
  assign n = (l & c & ~r) | (~l & c) | (~c & r);
endmodule

module rule110_frame_rx #(
  parameter int WORD_W   = 16,
  parameter int WORDS    = 16,
  parameter int CHECK_EN = 1,
  localparam int FRAME_W = WORD_W * WORDS,
  localparam int IDX_W   = $clog2(WORDS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WORD_W-1:0]  word_in,
  input  logic               word_valid,
  input  logic               frame_start,
  output logic [FRAME_W-1:0] frame_out,
  output logic               frame_valid,
  output logic               chk_valid,
  output logic               chk_match,
  output logic [7:0]         chk_fail_cnt,
  output logic [15:0]        gen_cnt,
  output logic               sync_err,
  output logic               busy
);

  typedef enum logic {IDLE, RECV} state_t;

  typedef struct packed {
    logic               pend;
    logic [FRAME_W-1:0] exp;
  } chk_stage_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  state_t                         state, state_nx;
  logic [IDX_W-1:0]               idx;
  logic [WORDS-1:0][WORD_W-1:0]   words_q;
  logic [FRAME_W-1:0]             frame_nx;
  logic [FRAME_W-1:0]             succ;
  logic                           have_prev;
  chk_stage_t                     chk_q;
  logic                           restart, accept, complete, sync_hit;

  // frame_out always holds the last completed frame, so it doubles as the history
  for (genvar i = 0; i < FRAME_W; i++) begin : g_cell
    rule110_cell u_cell (
      .l ((i == FRAME_W - 1) ? 1'b0 : frame_out[(i == FRAME_W - 1) ? i : i + 1]),
      .c (frame_out[i]),
      .r ((i == 0) ? 1'b0 : frame_out[(i == 0) ? 0 : i - 1]),
      .n (succ[i])
    );
  end

  assign frame_nx = {words_q[WORDS-1:1], word_in};
  assign busy     = (state == RECV);

  always_comb begin
    state_nx = state;
    restart  = 1'b0;
    accept   = 1'b0;
    complete = 1'b0;
    sync_hit = 1'b0;
    case (state)
      IDLE: begin
        if (word_valid && frame_start) begin
          restart  = 1'b1;
          state_nx = RECV;
        end
      end
      RECV: begin
        if (word_valid) begin
          if (frame_start) begin
            sync_hit = 1'b1;
            restart  = 1'b1;
          end else begin
            accept = 1'b1;
            if (idx == LAST) begin
              complete = 1'b1;
              state_nx = IDLE;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      words_q      <= '0;
      have_prev    <= 1'b0;
      chk_q        <= '0;
      frame_out    <= '0;
      frame_valid  <= 1'b0;
      chk_valid    <= 1'b0;
      chk_match    <= 1'b0;
      chk_fail_cnt <= '0;
      gen_cnt      <= '0;
      sync_err     <= 1'b0;
    end else begin
      state       <= state_nx;
      frame_valid <= complete;
      sync_err    <= sync_hit;

      if (restart) begin
        words_q[WORDS-1] <= word_in;
        idx              <= IDX_W'(1);
      end else if (accept) begin
        words_q[LAST - idx] <= word_in;
        idx                 <= complete ? '0 : idx + IDX_W'(1);
      end

      // stage 1: latch the predicted successor of the outgoing frame
      chk_q.pend <= 1'b0;
      if (complete) begin
        frame_out  <= frame_nx;
        gen_cnt    <= gen_cnt + 16'd1;
        have_prev  <= 1'b1;
        chk_q.pend <= have_prev && (CHECK_EN != 0);
        chk_q.exp  <= succ;
      end

      // stage 2: compare against the frame now on frame_out
      chk_valid <= chk_q.pend;
      if (chk_q.pend) begin
        chk_match <= (frame_out == chk_q.exp);
        if ((frame_out != chk_q.exp) && (chk_fail_cnt != 8'hFF))
          chk_fail_cnt <= chk_fail_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_rule110_frame_rx.sv
// Scoreboard bench for rule110_frame_rx: stimulus pushes expected frames, a monitor
// pops them on frame_valid and checks the trailing successor-check result.

module tb_rule110_frame_rx;
  logic         clk = 0;
  logic         rst_n = 0;
  logic [15:0]  word_in = '0;
  logic         word_valid = 0;
  logic         frame_start = 0;
  logic [255:0] frame_out;
  logic         frame_valid, chk_valid, chk_match, sync_err, busy;
  logic [7:0]   chk_fail_cnt;
  logic [15:0]  gen_cnt;

  int checks = 0;
  int failures = 0;
  int sync_seen = 0;
  int gen_m = 0;
  int fail_m = 0;

  // kind: 0 = no check expected, 1 = match expected, 2 = mismatch expected
  typedef struct {
    logic [255:0] f;
    logic [15:0]  g;
    int           kind;
    logic [7:0]   fc;
  } exp_t;
  exp_t q[$];

  rule110_frame_rx dut (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
    .frame_start(frame_start), .frame_out(frame_out), .frame_valid(frame_valid),
    .chk_valid(chk_valid), .chk_match(chk_match), .chk_fail_cnt(chk_fail_cnt),
    .gen_cnt(gen_cnt), .sync_err(sync_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put_word(input logic [15:0] w, input logic s);
    word_in = w; word_valid = 1; frame_start = s;
    @(posedge clk);
    #1;
    word_valid = 0; frame_start = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle(2);
    rst_n = 1;
    gen_m = 0;
    fail_m = 0;
  endtask

  task automatic send_frame(input logic [255:0] f, input int kind, input bit gaps, input int strays);
    logic [15:0] w;
    for (int s = 0; s < strays; s++) begin
      put_word(16'($urandom), 1'b0);
      if (gaps) idle($urandom_range(0, 5));
    end
    for (int k = 0; k < 16; k++) begin
      if (gaps && k > 0) idle($urandom_range(0, 5));
      w = f[255 - 16*k -: 16];
      if (k == 15) begin
        gen_m++;
        if (kind == 2 && fail_m < 255) fail_m++;
        q.push_back('{f, 16'(gen_m), kind, 8'(fail_m)});
      end
      put_word(w, k == 0);
    end
  endtask

  // monitor
  initial begin : mon
    logic [255:0] last;
    bit           pv;
    int           pk;
    logic [7:0]   pf;
    bit           ok;
    exp_t         e;
    last = '0; pv = 0; pk = 0; pf = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last = '0; pv = 0;
        continue;
      end
      if (sync_err) sync_seen++;
      if (pv) begin
        checks++;
        if (pk != 0) ok = chk_valid && (chk_match == (pk == 1)) && (chk_fail_cnt == pf);
        else         ok = !chk_valid;
        if (!ok) begin
          failures++;
          $display("FAIL chk_result actual valid=%0b match=%0b cnt=%0d required kind=%0d cnt=%0d",
                   chk_valid, chk_match, chk_fail_cnt, pk, pf);
        end
      end else if (chk_valid) begin
        checks++; failures++;
        $display("FAIL chk_stray actual chk_valid=1 required 0");
      end
      pv = 0;
      if (frame_valid) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL frame_stray actual frame_out=%h required no frame_valid", frame_out);
        end else begin
          e = q.pop_front();
          checks++;
          if (frame_out !== e.f || gen_cnt !== e.g) begin
            failures++;
            $display("FAIL frame actual=%h gen=%0d required=%h gen=%0d", frame_out, gen_cnt, e.f, e.g);
          end
          pv = 1; pk = e.kind; pf = e.fc; last = e.f;
        end
      end else begin
        checks++;
        if (frame_out !== last) begin
          failures++;
          $display("FAIL frame_stable actual=%h required=%h", frame_out, last);
        end
      end
    end
  end

  initial begin
    idle(3);
    rst_n = 1;
    check("reset_frame_out", frame_out, '0);
    check("reset_flags", {frame_valid, chk_valid, chk_match, sync_err, busy}, '0);
    check("reset_cnts", {chk_fail_cnt, gen_cnt}, '0);

    // first frame: no check
    put_word(16'h0000, 1'b1);
    check("busy_mid", busy, 1);
    for (int k = 1; k < 15; k++) put_word(16'h0000, 1'b0);
    gen_m = 1;
    q.push_back('{256'h1, 16'd1, 0, 8'd0});
    put_word(16'h0001, 1'b0);
    check("fv_latency", frame_valid, 1);
    check("busy_done", busy, 0);
    idle(1);
    check("no_first_chk", chk_valid, 0);

    // back-to-back successors
    send_frame(256'h3, 1, 0, 0);
    send_frame(256'h7, 1, 0, 0);
    send_frame(256'hD, 1, 0, 0);
    idle(1);
    check("chk_timing", chk_valid, 1);
    check("fail_zero", chk_fail_cnt, 0);
    check("gen4", gen_cnt, 4);

    // mismatch then saturation
    do_reset();
    send_frame(256'h1, 0, 0, 0);
    send_frame(256'h5, 2, 0, 0);
    idle(2);
    check("fail_one", chk_fail_cnt, 1);
    for (int n = 0; n < 300; n++) send_frame(256'h1, 2, 0, 0);
    idle(2);
    check("fail_sat", chk_fail_cnt, 255);

    // sync error: 7-word partial then a fresh all-ones frame
    for (int k = 0; k < 7; k++) put_word(16'hA5A5, k == 0);
    send_frame({256{1'b1}}, 2, 0, 0);
    idle(2);
    check("all_ones", frame_out, {256{1'b1}});

    // gaps and stray words: history = all ones -> 0x8000..0001 expected, 0x1 mismatches
    send_frame(256'h1, 2, 1, 3);
    send_frame(256'h3, 1, 1, 2);
    send_frame(256'h7, 1, 1, 1);
    send_frame(256'hD, 1, 1, 2);
    idle(3);

    // reset mid-frame
    for (int k = 0; k < 9; k++) put_word(16'h1234, k == 0);
    do_reset();
    check("mid_reset_frame", frame_out, '0);
    check("mid_reset_flags", {frame_valid, chk_valid, chk_match, sync_err, busy}, '0);
    check("mid_reset_cnts", {chk_fail_cnt, gen_cnt}, '0);
    send_frame(256'h7, 0, 0, 0);
    idle(3);
    check("gen_after_reset", gen_cnt, 1);

    idle(5);
    check("queue_empty", q.size(), 0);
    check("sync_err_count", sync_seen, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
